// File: rtl/ula_pkg.sv
// ula_pkg: shared widths, FSM state encoding, latched-operation struct and
// the control codes understood by the ULA.
package ula_pkg;

    localparam int LARGURA   = 16;
    localparam int LARG_CTRL = 5;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        EXECUTA  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    typedef struct packed {
        logic [LARGURA-1:0]   opA;
        logic [LARGURA-1:0]   opB;
        logic [LARG_CTRL-1:0] ctrl;
    } op_t;

    // ULA control codes; every other code yields zero.
    localparam logic [LARG_CTRL-1:0] ULA_SOMA  = 5'd0;
    localparam logic [LARG_CTRL-1:0] ULA_SUB   = 5'd1;
    localparam logic [LARG_CTRL-1:0] ULA_AND   = 5'd2;
    localparam logic [LARG_CTRL-1:0] ULA_OR    = 5'd3;
    localparam logic [LARG_CTRL-1:0] ULA_XOR   = 5'd4;
    localparam logic [LARG_CTRL-1:0] ULA_NOT   = 5'd5;
    localparam logic [LARG_CTRL-1:0] ULA_SHL   = 5'd6;
    localparam logic [LARG_CTRL-1:0] ULA_SHR   = 5'd7;
    localparam logic [LARG_CTRL-1:0] ULA_PASSA = 5'd8;
    localparam logic [LARG_CTRL-1:0] ULA_PASSB = 5'd9;

endpackage

// File: rtl/ula_arbitro_ula.sv
// ula: purely combinational arithmetic/logic unit.
// Ports:
//   operandoA, operandoB : LARGURA-bit operands
//   controle             : LARG_CTRL-bit operation select
//   resultadoOp          : LARGURA-bit result, same width as the operands
module ula
    import ula_pkg::*;
(
    input  logic [LARGURA-1:0]   operandoA,
    input  logic [LARGURA-1:0]   operandoB,
    input  logic [LARG_CTRL-1:0] controle,
    output logic [LARGURA-1:0]   resultadoOp
);

    // Operation decode; shifts use only the low 4 bits of operandoB.
    always_comb begin
        resultadoOp = '0;
        case (controle)
            ULA_SOMA:  resultadoOp = operandoA + operandoB;
            ULA_SUB:   resultadoOp = operandoA - operandoB;
            ULA_AND:   resultadoOp = operandoA & operandoB;
            ULA_OR:    resultadoOp = operandoA | operandoB;
            ULA_XOR:   resultadoOp = operandoA ^ operandoB;
            ULA_NOT:   resultadoOp = ~operandoA;
            ULA_SHL:   resultadoOp = operandoA << operandoB[3:0];
            ULA_SHR:   resultadoOp = operandoA >> operandoB[3:0];
            ULA_PASSA: resultadoOp = operandoA;
            ULA_PASSB: resultadoOp = operandoB;
            default:   resultadoOp = '0;
        endcase
    end

endmodule

// File: rtl/ula_arbitro.sv
// ula_arbitro: shares one ULA between two requesters with round-robin
// arbitration. One operation in flight: accept, execute, respond.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (bit i = requester i)
//   opA0/opB0/ctrl0     : operation of requester 0
//   opA1/opB1/ctrl1     : operation of requester 1
//   resp_valid/ready    : result handshake towards the consumer
//   resp_id             : requester that issued the held result
//   resultado           : registered ULA result
module ula_arbitro
    import ula_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [LARGURA-1:0]   opA0,
    input  logic [LARGURA-1:0]   opB0,
    input  logic [LARG_CTRL-1:0] ctrl0,
    input  logic [LARGURA-1:0]   opA1,
    input  logic [LARGURA-1:0]   opB1,
    input  logic [LARG_CTRL-1:0] ctrl1,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [LARGURA-1:0]   resultado
);

    estado_t              state_r;
    estado_t              next_state_s;
    logic                 prior_r;
    logic                 resp_id_r;
    logic                 resp_valid_r;
    logic [LARGURA-1:0]   resultado_r;
    op_t                  op_r;
    op_t                  op0_s;
    op_t                  op1_s;
    logic                 grant_s;
    logic                 grant_valid_s;
    logic [1:0]           req_ready_s;
    logic [LARGURA-1:0]   ula_out_s;

    assign op0_s = '{opA: opA0, opB: opB0, ctrl: ctrl0};
    assign op1_s = '{opA: opA1, opB: opB1, ctrl: ctrl1};

    // Round-robin grant, ready generation and next-state decode.
    always_comb begin
        next_state_s  = state_r;
        grant_s       = prior_r;
        grant_valid_s = 1'b0;
        req_ready_s   = 2'b00;
        case (state_r)
            OCIOSO: begin
                if (req_valid[prior_r]) begin
                    grant_s       = prior_r;
                    grant_valid_s = 1'b1;
                end else if (req_valid[~prior_r]) begin
                    grant_s       = ~prior_r;
                    grant_valid_s = 1'b1;
                end else begin
                    grant_s       = prior_r;
                    grant_valid_s = 1'b0;
                end
                // ready is raised only towards a requester that is already
                // valid, so grant_valid_s is the accept condition
                if (grant_valid_s && !rst) begin
                    req_ready_s  = (grant_s) ? 2'b10 : 2'b01;
                    next_state_s = EXECUTA;
                end else begin
                    req_ready_s  = 2'b00;
                    next_state_s = OCIOSO;
                end
            end
            EXECUTA: begin
                next_state_s = RESPONDE;
            end
            RESPONDE: begin
                if (resp_ready) begin
                    next_state_s = OCIOSO;
                end else begin
                    next_state_s = RESPONDE;
                end
            end
            default: begin
                next_state_s = OCIOSO;
            end
        endcase
    end

    // State register; resp_valid is registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= OCIOSO;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            resp_valid_r <= (next_state_s == RESPONDE);
        end
    end

    // Operation latch, result capture and priority update.
    always_ff @(posedge clk) begin
        if (rst) begin
            prior_r     <= 1'b0;
            resp_id_r   <= 1'b0;
            resultado_r <= '0;
            op_r        <= '0;
        end else begin
            case (state_r)
                OCIOSO: begin
                    if (grant_valid_s) begin
                        op_r      <= (grant_s) ? op1_s : op0_s;
                        resp_id_r <= grant_s;
                    end
                end
                EXECUTA: begin
                    resultado_r <= ula_out_s;
                end
                RESPONDE: begin
                    // the requester just served loses priority next round
                    if (resp_ready) begin
                        prior_r <= ~resp_id_r;
                    end
                end
                default: begin
                    prior_r <= prior_r;
                end
            endcase
        end
    end

    ula u_ula (
        .operandoA   (op_r.opA),
        .operandoB   (op_r.opB),
        .controle    (op_r.ctrl),
        .resultadoOp (ula_out_s)
    );

    assign req_ready  = req_ready_s;
    assign resp_valid = resp_valid_r;
    assign resp_id    = resp_id_r;
    assign resultado  = resultado_r;

endmodule

// File: tb/tb_ula_arbitro.sv
// Testbench for ula_arbitro: directed stimulus pushes hand-computed
// expected responses into a scoreboard; a negedge monitor pops and compares
// on every resp_valid && resp_ready handshake.
module tb_ula_arbitro;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] opA0, opB0, opA1, opB1;
    logic [4:0]  ctrl0, ctrl1;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [15:0] resultado;

    typedef struct {
        logic        id;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    ula_arbitro dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .opA0       (opA0),
        .opB0       (opB0),
        .ctrl0      (ctrl0),
        .opA1       (opA1),
        .opB1       (opB1),
        .ctrl1      (ctrl1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resultado  (resultado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic id, input logic [15:0] val);
        exp_t e;
        e.id  = id;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Wait until every expected response has been consumed and the DUT is idle.
    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !resp_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("wait_idle_timeout", {31'd0, done}, 32'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got id=%0d res=%0h expected no response", resp_id, resultado);
            end else begin
                e = sb.pop_front();
                chk("resp_id", {31'd0, resp_id}, {31'd0, e.id});
                chk("resultado", {16'd0, resultado}, {16'd0, e.val});
            end
        end
    end

    initial begin
        int          acc_cyc[$];
        int          n;
        logic [1:0]  exp_rr;

        // Reset hold with both requesters valid.
        rst = 1'b1; req_valid = 2'b11; resp_ready = 1'b1;
        opA0 = 16'h1234; opB0 = 16'h0011; ctrl0 = 5'd0;
        opA1 = 16'h0000; opB1 = 16'h0000; ctrl1 = 5'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
            chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("rst_resultado", {16'd0, resultado}, 32'd0);
        end
        sync();
        rst = 1'b0;
        push(1'b0, 16'h1245);
        @(negedge clk);
        chk("first_grant_req0", {30'd0, req_ready}, 32'd1);
        sync();
        req_valid = 2'b00;
        wait_idle(50);

        // Single op from requester 1: 5 + 3.
        sync();
        req_valid = 2'b10; opA1 = 16'h0005; opB1 = 16'h0003; ctrl1 = 5'd0;
        push(1'b1, 16'h0008);
        @(negedge clk);
        chk("single_req_ready", {30'd0, req_ready}, 32'd2);
        sync();
        req_valid = 2'b00;
        @(negedge clk);
        chk("single_exec_valid", {31'd0, resp_valid}, 32'd0);
        chk("single_exec_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("single_resp_valid", {31'd0, resp_valid}, 32'd1);
        wait_idle(50);

        // Contention: both valid, expect 0,1,0,1 with accepts 3 cycles apart.
        sync();
        req_valid = 2'b11;
        opA0 = 16'h00F0; opB0 = 16'h0F0F; ctrl0 = 5'd3;
        opA1 = 16'h0010; opB1 = 16'h0003; ctrl1 = 5'd1;
        push(1'b0, 16'h0FFF); push(1'b1, 16'h000D);
        push(1'b0, 16'h0FFF); push(1'b1, 16'h000D);
        n = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                exp_rr = (n % 2 == 0) ? 2'b01 : 2'b10;
                chk("contention_grant", {30'd0, req_ready}, {30'd0, exp_rr});
                acc_cyc.push_back(i);
                n++;
                if (n == 4) begin
                    @(posedge clk);
                    #1;
                    req_valid = 2'b00;
                end
            end
        end
        chk("contention_accepts", n, 4);
        for (int k = 1; k < 4; k++) begin
            if (acc_cyc.size() > k) begin
                chk("accept_interval", acc_cyc[k] - acc_cyc[k-1], 3);
            end
        end
        wait_idle(50);

        // Back-pressure: result held for 10 cycles while requester 1 waits.
        sync();
        resp_ready = 1'b0;
        req_valid = 2'b01; opA0 = 16'h0003; opB0 = 16'h0004; ctrl0 = 5'd4;
        push(1'b0, 16'h0007);
        @(negedge clk);
        chk("bp_req_ready", {30'd0, req_ready}, 32'd1);
        sync();
        req_valid = 2'b10; opA1 = 16'h0001; opB1 = 16'h0002; ctrl1 = 5'd6;
        push(1'b1, 16'h0004);
        @(negedge clk);
        chk("bp_exec_ready", {30'd0, req_ready}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_resultado", {16'd0, resultado}, 32'h0007);
            chk("bp_resp_id", {31'd0, resp_id}, 32'd0);
            chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
        end
        sync();
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_accept", {30'd0, req_ready}, 32'd2);
        sync();
        req_valid = 2'b00;
        wait_idle(50);

        // Operand stability: requester 0 waits with FFFF/0001 while 1 runs.
        sync();
        req_valid = 2'b10; opA1 = 16'h00FF; opB1 = 16'h0001; ctrl1 = 5'd8;
        push(1'b1, 16'h00FF);
        @(negedge clk);
        chk("stab_grant1", {30'd0, req_ready}, 32'd2);
        sync();
        req_valid = 2'b11; opA0 = 16'hFFFF; opB0 = 16'h0001; ctrl0 = 5'd0;
        push(1'b0, 16'h0000);
        @(negedge clk);
        chk("stab_exec_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("stab_resp_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("stab_grant0", {30'd0, req_ready}, 32'd1);
        sync();
        req_valid = 2'b00;
        wait_idle(50);

        // Reset during EXECUTA: no response, priority back to 0.
        sync();
        req_valid = 2'b01; opA0 = 16'h1111; opB0 = 16'h2222; ctrl0 = 5'd0;
        @(negedge clk);
        chk("rmid_grant", {30'd0, req_ready}, 32'd1);
        sync();
        req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        chk("rmid_no_valid", {31'd0, resp_valid}, 32'd0);
        sync();
        rst = 1'b0;
        req_valid = 2'b11;
        opA0 = 16'hABCD; opB0 = 16'h0001; ctrl0 = 5'd31;
        opA1 = 16'h0001; opB1 = 16'h0001; ctrl1 = 5'd0;
        push(1'b0, 16'h0000);
        @(negedge clk);
        chk("rmid_prior0", {30'd0, req_ready}, 32'd1);
        chk("rmid_valid_after", {31'd0, resp_valid}, 32'd0);
        chk("rmid_resultado", {16'd0, resultado}, 32'd0);
        sync();
        req_valid = 2'b00;
        wait_idle(50);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
